// File: rtl/dram_timing_gen_pkg.sv
// Shared types and constants for the DRAM strobe sequencer.
// State encoding, strobe levels and the counter load helper.
package dram_timing_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ROW  = 3'd1,
        ST_COLW = 3'd2,
        ST_CAS  = 3'd3,
        ST_PRE  = 3'd4,
        ST_REF  = 3'd5
    } state_e;

    localparam logic STROBE_ON  = 1'b0;
    localparam logic STROBE_OFF = 1'b1;

    localparam int CNT_W = 4;

    // Counter holds (cycles-1) on entry and counts down to zero.
    function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/dram_timing_gen_sync2.sv
// Two-flop synchronizer for the asynchronous Z80 strobes.
// Reset value is a parameter so inactive-high strobes reset high.
module dram_timing_gen_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    // Shift the raw input through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops, forced to the idle level on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/dram_timing_gen.sv
// Clocked RAS/MUX/CAS sequencer for two Z80 DRAM banks.
// Spaces row/column strobes and performs RAS-only refresh.
module dram_timing_gen
    import dram_timing_gen_pkg::*;
#(
    parameter int unsigned T_RAS_MUX = 1,
    parameter int unsigned T_MUX_CAS = 1,
    parameter int unsigned T_PRE     = 2,
    parameter int unsigned T_RFSH    = 3
) (
    input  logic CLK,
    input  logic RST,
    input  logic MREQ,
    input  logic RFSH,
    input  logic RD,
    input  logic WR,
    input  logic DSEL,
    input  logic BANK,
    output logic RAS1,
    output logic RAS2,
    output logic CAS1,
    output logic CAS2,
    output logic MUX,
    output logic BUSY
);

    logic mreq_s;
    logic rfsh_s;
    logic rd_s;
    logic wr_s;

    dram_timing_gen_sync2 #(.RST_VAL(1'b1)) u_sync_mreq (
        .clk (CLK),
        .rst (RST),
        .d   (MREQ),
        .q   (mreq_s)
    );

    dram_timing_gen_sync2 #(.RST_VAL(1'b1)) u_sync_rfsh (
        .clk (CLK),
        .rst (RST),
        .d   (RFSH),
        .q   (rfsh_s)
    );

    dram_timing_gen_sync2 #(.RST_VAL(1'b1)) u_sync_rd (
        .clk (CLK),
        .rst (RST),
        .d   (RD),
        .q   (rd_s)
    );

    dram_timing_gen_sync2 #(.RST_VAL(1'b1)) u_sync_wr (
        .clk (CLK),
        .rst (RST),
        .d   (WR),
        .q   (wr_s)
    );

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bank_q, bank_d;
    logic             ras1_q, ras1_d;
    logic             ras2_q, ras2_d;
    logic             cas1_q, cas1_d;
    logic             cas2_q, cas2_d;
    logic             mux_q, mux_d;
    logic             busy_q, busy_d;
    logic             row_act;

    // Next state, counter and latched bank selection.
    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        cnt_d   = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (!mreq_s && !rfsh_s) begin
                    state_d = ST_REF;
                    cnt_d   = cnt_load(T_RFSH);
                end else if (!mreq_s && DSEL) begin
                    state_d = ST_ROW;
                    cnt_d   = cnt_load(T_RAS_MUX);
                    bank_d  = BANK;
                end
            end
            ST_ROW: begin
                if (mreq_s) begin
                    state_d = ST_PRE;
                    cnt_d   = cnt_load(T_PRE);
                end else if (cnt_q == '0) begin
                    state_d = ST_COLW;
                    cnt_d   = cnt_load(T_MUX_CAS);
                end
            end
            ST_COLW: begin
                if (mreq_s) begin
                    state_d = ST_PRE;
                    cnt_d   = cnt_load(T_PRE);
                end else if (cnt_q == '0 && (!rd_s || !wr_s)) begin
                    state_d = ST_CAS;
                    cnt_d   = '0;
                end
            end
            ST_CAS: begin
                if (mreq_s) begin
                    state_d = ST_PRE;
                    cnt_d   = cnt_load(T_PRE);
                end
            end
            ST_PRE: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
            ST_REF: begin
                if (cnt_q == '0) begin
                    state_d = ST_PRE;
                    cnt_d   = cnt_load(T_PRE);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Strobe levels decoded from the state being entered, so they register with it.
    always_comb begin
        row_act = (state_d == ST_ROW) ||
                  (state_d == ST_COLW) ||
                  (state_d == ST_CAS);
        ras1_d  = STROBE_OFF;
        ras2_d  = STROBE_OFF;
        cas1_d  = STROBE_OFF;
        cas2_d  = STROBE_OFF;
        mux_d   = (state_d == ST_COLW) || (state_d == ST_CAS);
        busy_d  = (state_d != ST_IDLE);
        if (state_d == ST_REF) begin
            ras1_d = STROBE_ON;
            ras2_d = STROBE_ON;
        end else if (row_act) begin
            ras1_d = bank_d ? STROBE_OFF : STROBE_ON;
            ras2_d = bank_d ? STROBE_ON : STROBE_OFF;
        end
        if (state_d == ST_CAS) begin
            cas1_d = bank_d ? STROBE_OFF : STROBE_ON;
            cas2_d = bank_d ? STROBE_ON : STROBE_OFF;
        end
    end

    // State, counter and registered strobe outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bank_q  <= 1'b0;
            ras1_q  <= STROBE_OFF;
            ras2_q  <= STROBE_OFF;
            cas1_q  <= STROBE_OFF;
            cas2_q  <= STROBE_OFF;
            mux_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bank_q  <= bank_d;
            ras1_q  <= ras1_d;
            ras2_q  <= ras2_d;
            cas1_q  <= cas1_d;
            cas2_q  <= cas2_d;
            mux_q   <= mux_d;
            busy_q  <= busy_d;
        end
    end

    assign RAS1 = ras1_q;
    assign RAS2 = ras2_q;
    assign CAS1 = cas1_q;
    assign CAS2 = cas2_q;
    assign MUX  = mux_q;
    assign BUSY = busy_q;

endmodule

// File: tb/tb_dram_timing_gen.sv
// Directed scoreboard bench for dram_timing_gen.
// Expected strobe vectors are queued per edge and checked #1 after it.
module tb_dram_timing_gen;

    logic CLK = 1'b0;
    logic RST;
    logic MREQ;
    logic RFSH;
    logic RD;
    logic WR;
    logic DSEL;
    logic BANK;
    logic RAS1;
    logic RAS2;
    logic CAS1;
    logic CAS2;
    logic MUX;
    logic BUSY;

    dram_timing_gen dut (
        .CLK  (CLK),
        .RST  (RST),
        .MREQ (MREQ),
        .RFSH (RFSH),
        .RD   (RD),
        .WR   (WR),
        .DSEL (DSEL),
        .BANK (BANK),
        .RAS1 (RAS1),
        .RAS2 (RAS2),
        .CAS1 (CAS1),
        .CAS2 (CAS2),
        .MUX  (MUX),
        .BUSY (BUSY)
    );

    always #5 CLK = ~CLK;

    // {RAS1, RAS2, CAS1, CAS2, MUX, BUSY}
    localparam logic [5:0] O_IDLE = 6'b111100;
    localparam logic [5:0] O_PRE  = 6'b111101;
    localparam logic [5:0] O_REF  = 6'b001101;
    localparam logic [5:0] O_R1   = 6'b011101;
    localparam logic [5:0] O_W1   = 6'b011111;
    localparam logic [5:0] O_C1   = 6'b010111;
    localparam logic [5:0] O_R2   = 6'b101101;
    localparam logic [5:0] O_W2   = 6'b101111;
    localparam logic [5:0] O_C2   = 6'b101011;

    typedef struct {
        string      tag;
        logic [5:0] v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [5:0] obs;
    assign obs = {RAS1, RAS2, CAS1, CAS2, MUX, BUSY};

    task automatic push(input string tag, input logic [5:0] v, input int n = 1);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        for (int i = 0; i < n; i++) sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(posedge CLK);
            #1;
            checks++;
            assert (obs === e.v) else begin
                errors++;
                $error("FAIL %s: observed %b expected %b", e.tag, obs, e.v);
            end
        end
    endtask

    initial begin
        RST  = 1'b1;
        MREQ = 1'b1;
        RFSH = 1'b1;
        RD   = 1'b1;
        WR   = 1'b1;
        DSEL = 1'b0;
        BANK = 1'b0;
        push("reset", O_IDLE, 2);
        drain();
        RST = 1'b0;
        push("idle", O_IDLE, 2);
        drain();

        // Read bank 1
        DSEL = 1'b1;
        BANK = 1'b0;
        MREQ = 1'b0;
        RD   = 1'b0;
        push("rd1_sync", O_IDLE, 2);
        push("rd1_row", O_R1);
        push("rd1_colw", O_W1);
        push("rd1_cas", O_C1, 2);
        drain();
        MREQ = 1'b1;
        RD   = 1'b1;
        push("rd1_hold", O_C1, 2);
        push("rd1_pre", O_PRE, 2);
        push("rd1_idle", O_IDLE, 2);
        drain();

        // Write bank 2, WR late; DSEL/BANK change after latching
        DSEL = 1'b1;
        BANK = 1'b1;
        MREQ = 1'b0;
        push("wr2_sync", O_IDLE, 2);
        push("wr2_row", O_R2);
        drain();
        BANK = 1'b0;
        DSEL = 1'b0;
        push("wr2_latch", O_W2);
        drain();
        WR = 1'b0;
        push("wr2_wait", O_W2, 2);
        push("wr2_cas", O_C2, 2);
        drain();
        MREQ = 1'b1;
        WR   = 1'b1;
        push("wr2_hold", O_C2, 2);
        push("wr2_pre", O_PRE, 2);
        push("wr2_idle", O_IDLE, 2);
        drain();

        // Refresh
        MREQ = 1'b0;
        RFSH = 1'b0;
        push("ref_sync", O_IDLE, 2);
        push("ref_ras", O_REF);
        drain();
        MREQ = 1'b1;
        RFSH = 1'b1;
        push("ref_ras", O_REF, 2);
        push("ref_pre", O_PRE, 2);
        push("ref_idle", O_IDLE, 2);
        drain();

        // Non-DRAM access
        DSEL = 1'b0;
        MREQ = 1'b0;
        RD   = 1'b0;
        push("nodram", O_IDLE, 5);
        drain();
        MREQ = 1'b1;
        RD   = 1'b1;
        push("nodram_end", O_IDLE, 3);
        drain();

        // Back-to-back: MREQ pulses high for one cycle
        DSEL = 1'b1;
        BANK = 1'b0;
        MREQ = 1'b0;
        RD   = 1'b0;
        push("b2b_sync", O_IDLE, 2);
        push("b2b_row", O_R1);
        push("b2b_colw", O_W1);
        push("b2b_cas", O_C1);
        drain();
        MREQ = 1'b1;
        push("b2b_cas", O_C1);
        drain();
        MREQ = 1'b0;
        push("b2b_cas", O_C1);
        push("b2b_pre", O_PRE, 2);
        push("b2b_gap", O_IDLE);
        push("b2b_row2", O_R1);
        push("b2b_colw2", O_W1);
        push("b2b_cas2", O_C1);
        drain();
        MREQ = 1'b1;
        RD   = 1'b1;
        push("b2b_hold", O_C1, 2);
        push("b2b_pre2", O_PRE, 2);
        push("b2b_idle", O_IDLE);
        drain();

        // Reset in the middle of a bank 2 write
        DSEL = 1'b1;
        BANK = 1'b1;
        MREQ = 1'b0;
        WR   = 1'b0;
        push("rst_sync", O_IDLE, 2);
        push("rst_row", O_R2);
        push("rst_colw", O_W2);
        push("rst_cas", O_C2);
        drain();
        RST  = 1'b1;
        MREQ = 1'b1;
        WR   = 1'b1;
        push("rst_mid", O_IDLE, 2);
        drain();
        RST = 1'b0;
        push("rst_after", O_IDLE, 3);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
